ib_vnu_lut_loader: RTL and testbench
====================================

Name: ib_vnu_lut_loader

Overview:
- Write-side controller for the IB-VNU function LUT RAM that the VNU sub-datapaths read.
- Accepts a valid/ready stream of LUT words for one decoding iteration and sweeps every page address exactly once.
- Drives the RAM write port: page address, where the MSB is the multi-frame write offset; bank-packed write data; and write enable.
- Reports completion with a done pulse, an update counter and a sticky framing-error flag.

Parameters:
- ENTRY_ADDR, 7, page address width; MSB selects the frame half; page count is 2^ENTRY_ADDR.
- BANK_NUM, 2, banks written per page.
- LUT_PORT_SIZE, 4, bits per bank entry.
- ITER_W, 5, width of the update counter.

Ports:
- write_clk  input  1  sole clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a full LUT load.
- in_valid  input  1  upstream LUT word valid.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  LUT_PORT_SIZE*BANK_NUM  packed word; upper LUT_PORT_SIZE bits go to bank0, lower bits to bank1.
- in_last  input  1  upstream marks the final word of the set.
- page_addr_ram  output  ENTRY_ADDR  RAM write page address.
- ram_write_data_1  output  LUT_PORT_SIZE*BANK_NUM  RAM write data.
- ib_ram_we  output  1  RAM write enable.
- busy  output  1  high in LOAD and DONE.
- done  output  1  single-cycle pulse when the load completes.
- iter_cnt  output  ITER_W  number of completed loads; wraps to 0 after 2^ITER_W-1.
- err  output  1  sticky framing error, cleared by the next accepted start.

Behaviour:
- Reset values: in_ready=0, page_addr_ram=0, ram_write_data_1=0, ib_ram_we=0, busy=0, done=0, iter_cnt=0, err=0. The FSM goes to IDLE and the internal address counter goes to 0.
- Reset asserted mid-load aborts on the next edge. The RAM is left partially written and no done pulse is generated.
- FSM states:
  - IDLE: in_ready=0. start=1 clears the address counter and err, then goes to LOAD.
  - LOAD: in_ready=1. Each handshake (in_valid & in_ready) registers in_data into ram_write_data_1 and the counter value into page_addr_ram, and asserts ib_ram_we in the next cycle (latency 1, one write per handshake). The counter then increments. A handshake at counter = 2^ENTRY_ADDR-1 moves to DONE, with in_ready low from the next cycle.
  - DONE: lasts one cycle. done=1 and iter_cnt increments. The final write (address 2^ENTRY_ADDR-1) occurs in this same cycle. Returns to IDLE.
- ib_ram_we is low in every cycle not preceded by a handshake. page_addr_ram and ram_write_data_1 hold their last values when ib_ram_we=0.
- in_valid=0 during LOAD stalls the sweep with no write. There is no timeout.
- The address counter is ENTRY_ADDR bits. Its MSB naturally steps the write offset from frame half 0 to half 1 at address 2^(ENTRY_ADDR-1). The counter never wraps within a load, because the wrap point is the transition to DONE.
- Framing check, on every handshake:
  - in_last=1 at any address other than the final one sets err.
  - in_last=0 at the final address sets err.
  - The load still runs to the full page count regardless.
- start while busy=1 is ignored, with no effect on the counter or err.
- start in the same cycle as rst is ignored; reset wins.
- in_valid/in_data/in_last in IDLE or DONE are ignored (no handshake, no write).

Test Plan:
- Reset, then start, then 128 back-to-back words with in_data = address[7:0] and in_last on word 127 -> 128 writes at page_addr_ram 0..127, each one cycle after its handshake. done pulses once in the cycle of write 127, iter_cnt=1, err=0, in_ready low after word 127.
- Same load with in_valid toggling 1/0 every cycle -> exactly 128 ib_ram_we pulses, addresses strictly consecutive, no write in any cycle after a non-handshake cycle.
- in_last asserted on word 50 and deasserted on word 127 -> err=1 after word 50 and held. All 128 writes still occur and done pulses. The next start clears err to 0.
- rst asserted after 70 words -> next cycle ib_ram_we=0, busy=0, in_ready=0. Outputs return to reset values and done never pulses.
- start pulsed again at word 30 of a load -> ignored; the sweep continues to address 127 with a single done pulse.
- 32 consecutive complete loads with ITER_W=5 -> iter_cnt reads 31 after load 31 and wraps to 0 after load 32. Bank check for in_data=8'hA5: bank0 nibble is 4'hA, bank1 nibble is 4'h5, and ram_write_data_1=8'hA5.

Source files
------------

// File: rtl/ib_vnu_lut_loader.sv
// ib_vnu_lut_loader: sweeps every LUT RAM page once per load from a valid/ready word stream
module ib_vnu_lut_loader #(
  parameter int ENTRY_ADDR    = 7,
  parameter int BANK_NUM      = 2,
  parameter int LUT_PORT_SIZE = 4,
  parameter int ITER_W        = 5
) (
  input  logic                              write_clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] in_data,
  input  logic                              in_last,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
  output logic                              ib_ram_we,
  output logic                              busy,
  output logic                              done,
  output logic [ITER_W-1:0]                 iter_cnt,
  output logic                              err
);
  typedef enum logic [1:0] {IDLE, LOAD, FIN} state_t;
  state_t state, nxt;
  logic [ENTRY_ADDR-1:0] addr_cnt;
  logic hs, last_addr;
  assign hs        = in_valid & in_ready;
  assign last_addr = &addr_cnt;
  always_ff @(posedge write_clk)
    if (rst) state <= IDLE;
    else     state <= nxt;
  always_comb
    nxt = state == IDLE ? (start ? LOAD : IDLE)
        : state == LOAD ? ((hs && last_addr) ? FIN : LOAD)
        : IDLE;
  always_comb begin
    in_ready = state == LOAD;
    busy     = state != IDLE;
    done     = state == FIN;
  end
  // Bank 0 occupies the upper slice of the word, so the packed input maps straight onto the RAM port.
  always_ff @(posedge write_clk)
    if (rst) begin
      addr_cnt         <= '0;
      page_addr_ram    <= '0;
      ram_write_data_1 <= '0;
      ib_ram_we        <= 1'b0;
      iter_cnt         <= '0;
      err              <= 1'b0;
    end else begin
      ib_ram_we <= hs;
      if (state == IDLE && start) begin
        addr_cnt <= '0;
        err      <= 1'b0;
      end
      if (hs) begin
        page_addr_ram    <= addr_cnt;
        ram_write_data_1 <= in_data;
        addr_cnt         <= addr_cnt + 1'b1;
        if (in_last != last_addr) err <= 1'b1;
      end
      if (state == FIN) iter_cnt <= iter_cnt + 1'b1;
    end
endmodule

// File: tb/tb_ib_vnu_lut_loader.sv
// tb_ib_vnu_lut_loader: directed scenarios for the LUT RAM loader
module tb_ib_vnu_lut_loader;
  logic       clk = 0, rst = 0, start = 0, in_valid = 0, in_last = 0;
  logic [7:0] in_data = 0;
  logic       in_ready, ib_ram_we, busy, done, err;
  logic [6:0] page_addr_ram;
  logic [7:0] ram_write_data_1;
  logic [4:0] iter_cnt;
  int         tests = 0, fails = 0;
  logic [4:0] exp_iter = 0;

  ib_vnu_lut_loader dut (
    .write_clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .page_addr_ram(page_addr_ram),
    .ram_write_data_1(ram_write_data_1), .ib_ram_we(ib_ram_we), .busy(busy), .done(done),
    .iter_cnt(iter_cnt), .err(err)
  );

  always #5 clk = ~clk;

  // Runs one load; checks every cycle. Returns 1 when the load ran to completion.
  task automatic run_load(input bit toggle, input int last_idx, input int abort_at,
                          input int restart_at, input bit use_a5, output bit completed);
    int w = 0, cyc = 0;
    bit v, exp_err = 0, aborted = 0;
    logic [7:0] d;
    completed = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    tests++;
    if ({busy, in_ready, err, ib_ram_we, done} !== 5'b11000) begin
      fails++; $display("FAIL start_accept got %b exp 11000", {busy, in_ready, err, ib_ram_we, done});
    end
    while (w < 128 && cyc < 1000 && !aborted) begin
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      d = use_a5 ? 8'hA5 : w[7:0];
      in_valid = v; in_data = d; in_last = (w == last_idx);
      start = (w == restart_at);
      if (w == abort_at) rst = 1;
      @(posedge clk); #1;
      start = 0;
      tests++;
      if (rst) begin
        rst = 0; in_valid = 0; aborted = 1; exp_iter = 0;
        if ({ib_ram_we, busy, in_ready, done, err, page_addr_ram, ram_write_data_1, iter_cnt} !== '0) begin
          fails++; $display("FAIL abort_reset got we=%b busy=%b rdy=%b done=%b err=%b addr=%0d data=%h iter=%0d exp all 0",
                            ib_ram_we, busy, in_ready, done, err, page_addr_ram, ram_write_data_1, iter_cnt);
        end
      end else if (v) begin
        exp_err |= (in_last != (w == 127));
        if ({ib_ram_we, page_addr_ram, ram_write_data_1, err, done, in_ready}
            !== {1'b1, w[6:0], d, exp_err, w == 127, w != 127}) begin
          fails++; $display("FAIL write w=%0d got we=%b addr=%0d data=%h err=%b done=%b rdy=%b exp addr=%0d data=%h err=%b",
                            w, ib_ram_we, page_addr_ram, ram_write_data_1, err, done, in_ready, w, d, exp_err);
        end
        w++;
      end else if ({ib_ram_we, done, in_ready} !== 3'b001) begin
        fails++; $display("FAIL stall w=%0d got we=%b done=%b rdy=%b exp 0 0 1", w, ib_ram_we, done, in_ready);
      end
      cyc++;
    end
    if (aborted) return;
    tests++;
    if (cyc >= 1000) begin
      fails++; $display("FAIL timeout got %0d words exp 128", w);
      return;
    end
    in_valid = 1; in_last = 0; in_data = 8'h3C;
    @(posedge clk); #1;
    in_valid = 0;
    exp_iter = exp_iter + 1'b1;
    if ({done, busy, in_ready, ib_ram_we, page_addr_ram, ram_write_data_1, err, iter_cnt}
        !== {4'b0000, 7'd127, d, exp_err, exp_iter}) begin
      fails++; $display("FAIL after_done got done=%b busy=%b rdy=%b we=%b addr=%0d data=%h err=%b iter=%0d exp addr=127 data=%h err=%b iter=%0d",
                        done, busy, in_ready, ib_ram_we, page_addr_ram, ram_write_data_1, err, iter_cnt, d, exp_err, exp_iter);
    end
    completed = 1;
  endtask

  task automatic test_reset;
    rst = 1; start = 1;
    @(posedge clk); #1;
    rst = 0; start = 0;
    tests++;
    if ({in_ready, page_addr_ram, ram_write_data_1, ib_ram_we, busy, done, iter_cnt, err} !== '0) begin
      fails++; $display("FAIL reset_values got rdy=%b addr=%0d data=%h we=%b busy=%b done=%b iter=%0d err=%b exp all 0",
                        in_ready, page_addr_ram, ram_write_data_1, ib_ram_we, busy, done, iter_cnt, err);
    end
    in_valid = 1; in_data = 8'hFF; in_last = 1;
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
    tests++;
    if ({busy, ib_ram_we, in_ready, err} !== 4'b0000) begin
      fails++; $display("FAIL idle_ignore got busy=%b we=%b rdy=%b err=%b exp 0000", busy, ib_ram_we, in_ready, err);
    end
    exp_iter = 0;
  endtask

  task automatic test_basic;
    bit c;
    run_load(0, 127, -1, -1, 0, c);
  endtask

  task automatic test_stall;
    bit c;
    run_load(1, 127, -1, -1, 0, c);
  endtask

  task automatic test_framing;
    bit c;
    run_load(0, 50, -1, -1, 0, c);
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL err_sticky got %b exp 1", err);
    end
    run_load(0, 127, -1, -1, 0, c);
  endtask

  task automatic test_abort;
    bit c;
    run_load(0, 127, 70, -1, 0, c);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({done, busy, ib_ram_we} !== 3'b000) begin
        fails++; $display("FAIL abort_quiet got done=%b busy=%b we=%b exp 000", done, busy, ib_ram_we);
      end
    end
  endtask

  task automatic test_restart;
    bit c;
    run_load(0, 127, -1, 30, 0, c);
  endtask

  task automatic test_iter_wrap;
    bit c;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_iter = 0;
    for (int k = 1; k <= 32; k++) begin
      run_load(0, 127, -1, -1, 1, c);
      if (k == 1) begin
        tests++;
        if ({ram_write_data_1[7:4], ram_write_data_1[3:0]} !== {4'hA, 4'h5}) begin
          fails++; $display("FAIL bank_split got bank0=%h bank1=%h exp a 5", ram_write_data_1[7:4], ram_write_data_1[3:0]);
        end
      end
      if (k == 31) begin
        tests++;
        if (iter_cnt !== 5'd31) begin
          fails++; $display("FAIL iter_31 got %0d exp 31", iter_cnt);
        end
      end
    end
    tests++;
    if (iter_cnt !== 5'd0) begin
      fails++; $display("FAIL iter_wrap got %0d exp 0", iter_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_framing;
    test_abort;
    test_restart;
    test_iter_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
